// File: rtl/uart_param_core.sv
// uart_param_core: parametrised full-duplex UART (DATA_BITS data, optional
// even/odd parity, 1 or 2 stop bits) with an oversampled receiver.
//
// State table (both FSMs):
//   state      | meaning
//   TX_IDLE    | line idle high, waiting for tx_start
//   TX_START   | frame accepted; waiting for tick, then start bit low
//   TX_DATA    | shifting data bits out, LSB first
//   TX_PARITY  | parity bit on the line (PARITY != 0 only)
//   TX_STOP    | STOP_BITS high bit times, tx_done at the end
//   RX_IDLE    | waiting for synced rx low
//   RX_START   | half-bit wait, then confirm start bit (false-start reject)
//   RX_DATA    | mid-bit sampling of data bits, LSB first
//   RX_PARITY  | mid-bit sampling of parity bit (PARITY != 0 only)
//   RX_STOP    | mid-bit sample of first stop bit, frame completion
//   RX_BREAK   | stop bit was low; wait for rx high before re-arming
//
// Ports:
//   clock, reset        system clock, async active-low reset
//   rx                  serial input (asynchronous, idle high)
//   tx_in, tx_start     transmit data / level request
//   tx, tx_busy, tx_done
//   rx_out, rx_valid, rx_ack, rx_done
//   rx_parity_err, rx_frame_err, rx_overrun
module uart_param_core #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int TICK_DIV   = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    input  logic [DATA_BITS-1:0] tx_in,
    input  logic                 tx_start,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic [DATA_BITS-1:0] rx_out,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 rx_done,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int TDW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BCW = 4;

    localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_HALF   = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
    localparam logic           PAR_EN    = (PARITY != 0);
    localparam logic           PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_t;

    // ------------------------------------------------------------------
    // Shared tick generator
    // ------------------------------------------------------------------
    logic [TDW-1:0] tick_cnt_q;
    logic           tick;

    assign tick = (tick_cnt_q == TDW'(TICK_DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TDW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [BCW-1:0]       tx_bcnt_q, tx_bcnt_d;
    logic [OSW-1:0]       tx_tcnt_q, tx_tcnt_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_done_q, tx_done_d;
    logic                 tx_bit_end;

    assign tx_bit_end = tick && (tx_tcnt_q == '0);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bcnt_d  = tx_bcnt_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_done_d  = 1'b0;

        // Bit-time down-counter; reloads itself at terminal count.
        if (tick) begin
            tx_tcnt_d = (tx_tcnt_q == '0) ? OS_LAST : tx_tcnt_q - OSW'(1);
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_in;
                    tx_par_d   = (^tx_in) ^ PAR_ODD;
                    tx_tcnt_d  = OS_LAST;
                end
            end
            TX_START: begin
                // tx still high means the start bit has not been launched yet.
                if (tick && tx_q) begin
                    tx_d      = 1'b0;
                    tx_tcnt_d = OS_LAST;
                end else if (tx_bit_end) begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bcnt_d  = DATA_LAST;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bcnt_q == '0) begin
                        if (PAR_EN) begin
                            tx_d       = tx_par_q;
                            tx_state_d = TX_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            tx_bcnt_d  = STOP_LAST;
                            tx_state_d = TX_STOP;
                        end
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bcnt_d  = tx_bcnt_q - BCW'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_d       = 1'b1;
                    tx_bcnt_d  = STOP_LAST;
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bcnt_q == '0) begin
                        tx_state_d = TX_IDLE;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_bcnt_d = tx_bcnt_q - BCW'(1);
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_bcnt_q  <= '0;
            tx_tcnt_q  <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bcnt_q  <= tx_bcnt_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (tx_state_q != TX_IDLE);
    assign tx_done = tx_done_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                 rx_meta_q, rx_sync_q;
    rx_state_t            rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [BCW-1:0]       rx_bcnt_q, rx_bcnt_d;
    logic [OSW-1:0]       rx_tcnt_q, rx_tcnt_d;
    logic                 rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0] rx_out_q, rx_out_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_done_q, rx_done_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_ovr_q, rx_ovr_d;
    logic                 rx_bit_end;

    assign rx_bit_end = tick && (rx_tcnt_q == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_par_d   = rx_par_q;
        rx_out_d   = rx_out_q;
        rx_valid_d = rx_valid_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_ovr_d   = rx_ovr_q;
        rx_done_d  = 1'b0;

        if (tick) begin
            rx_tcnt_d = (rx_tcnt_q == '0) ? OS_LAST : rx_tcnt_q - OSW'(1);
        end

        if (rx_ack) begin
            rx_valid_d = 1'b0;
            rx_ovr_d   = 1'b0;
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_tcnt_d  = OS_HALF;
                end
            end
            RX_START: begin
                if (rx_bit_end) begin
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_bcnt_d  = DATA_LAST;
                        rx_state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bcnt_q == '0) begin
                        rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bcnt_d = rx_bcnt_q - BCW'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (rx_bit_end) begin
                    rx_par_d   = rx_sync_q;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_out_d   = rx_shift_q;
                    rx_perr_d  = PAR_EN & ((^rx_shift_q) ^ rx_par_q ^ PAR_ODD);
                    rx_ferr_d  = ~rx_sync_q;
                    rx_done_d  = 1'b1;
                    // Completion beats a coincident ack: valid stays set.
                    rx_valid_d = 1'b1;
                    if (rx_valid_q && !rx_ack) begin
                        rx_ovr_d = 1'b1;
                    end
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_bcnt_q  <= '0;
            rx_tcnt_q  <= '0;
            rx_par_q   <= 1'b0;
            rx_out_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_bcnt_q  <= rx_bcnt_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_par_q   <= rx_par_d;
            rx_out_q   <= rx_out_d;
            rx_valid_q <= rx_valid_d;
            rx_done_q  <= rx_done_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    assign rx_out        = rx_out_q;
    assign rx_valid      = rx_valid_q;
    assign rx_done       = rx_done_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_overrun    = rx_ovr_q;

endmodule

// File: doc/uart_param_core.md
Name: uart_param_core

Overview:
Parametrised full-duplex UART core, successor to the fixed 8N1 UART. Adds configurable data width, parity and stop bits, plus an oversampled receiver with false-start rejection and error flags. Adds a valid/ack receive handshake with overrun detection. Sits between the system clock domain and the serial pins; a host drives tx_in/tx_start and consumes rx_out.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 none, 1 even, 2 odd
STOP_BITS, 1, transmitted stop bits, legal 1 or 2
OVERSAMPLE, 16, ticks per bit, even, >=8
TICK_DIV, 7, clock cycles per tick, >=1 (bit time = OVERSAMPLE*TICK_DIV cycles)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rx  in  1  serial input, idle high, asynchronous to clock
tx_in  in  DATA_BITS  transmit data, sampled when a start is accepted
tx_start  in  1  transmit request, level
tx  out  1  serial output, idle high
tx_busy  out  1  high from acceptance through the last stop bit
tx_done  out  1  one-cycle pulse when a frame completes
rx_out  out  DATA_BITS  last received data
rx_valid  out  1  high from frame completion until rx_ack
rx_ack  in  1  host consumes rx_out; clears rx_valid
rx_done  out  1  one-cycle pulse when a frame completes
rx_parity_err  out  1  parity mismatch on last frame (0 if PARITY=0)
rx_frame_err  out  1  stop bit sampled low on last frame
rx_overrun  out  1  sticky; set when a frame completes while rx_valid=1; cleared by rx_ack

Behaviour:
- Reset (reset=0, async): tx=1. tx_busy, tx_done, rx_done, rx_valid and all error flags are 0. rx_out=0. Both FSMs go to IDLE. The rx synchroniser is preset to 1. Reset mid-frame aborts immediately; no done pulse is produced.
- Tick generator: a counter runs 0..TICK_DIV-1 continuously and pulses tick on wrap. TX and RX share it.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - In IDLE with tx_start=1, the FSM latches tx_in and sets tx_busy the next cycle.
  - tx drops to 0 on the next tick boundary.
  - Each bit lasts OVERSAMPLE ticks. Data goes out LSB first.
  - Parity bit: XOR of the data bits (even), or its inverse (odd).
  - STOP lasts STOP_BITS bit times.
  - tx_done pulses on the cycle the final stop bit ends; tx_busy drops in the same cycle.
  - tx_start while busy is ignored. tx_start held high restarts a new frame the cycle after tx_done (back-to-back).
- RX path:
  - rx passes through a 2-flop synchroniser.
  - IDLE: waits for synced rx=0.
  - START: counts OVERSAMPLE/2 ticks and resamples. If high, it is a false start: return to IDLE with no flags. If low, go to DATA.
  - DATA: samples every OVERSAMPLE ticks (mid-bit), shifting LSB first.
  - PARITY: sampled and checked when enabled.
  - STOP: samples only the first stop bit, at mid-bit.
  - At the STOP sample the block updates rx_out, rx_parity_err and rx_frame_err, pulses rx_done for one cycle, sets rx_valid and returns to IDLE. With a low stop bit it waits for rx high before re-arming.
  - Overrun: if rx_valid=1 at frame completion, rx_out is still overwritten and rx_overrun is set.
  - rx_ack clears rx_valid and rx_overrun. If rx_ack and a completion coincide, the completion wins: rx_valid stays 1 and overrun is not set.
- TX and RX are fully independent. Simultaneous operation is required.

Test Plan:
- Defaults, tx_in=8'h75, tx_start pulse: bits on tx are 0,1,0,1,0,1,1,1,0,1, each 112 cycles. tx_done pulses once, 1120 cycles after tx first goes low. tx_busy is high throughout.
- Loopback tx->rx, PARITY=1, frame 8'h75: rx_out=8'h75, rx_parity_err=0 and rx_done pulses once. Parity bit on the line is 1; with PARITY=2 it is 0.
- Inject frame 8'hA5 with a wrong parity bit (PARITY=1): rx_parity_err=1, rx_out=8'hA5. With stop bit forced low instead: rx_frame_err=1.
- 30-cycle low glitch on idle rx: no rx_done, no rx_valid, no flag change.
- Two frames 8'h11 and 8'h22 with no rx_ack: rx_out=8'h22, rx_overrun=1, rx_valid=1. An rx_ack pulse clears both.
- Assert reset low mid-data-bit during a TX and RX frame: tx=1 immediately, with no tx_done or rx_done. After release, frame 8'h3C transmits and receives correctly with DATA_BITS=7, STOP_BITS=2 (rx_out=7'h3C).
